// File: rtl/model_reader_pkg.sv
// ============================================================================
// model_reader_pkg : fixed-point vertex and triangle types shared by the model
//                    buffer, its loader and the model_reader block.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package model_reader_pkg;

  localparam int c_fixed_width = 16;

  typedef logic signed [c_fixed_width-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

endpackage

`default_nettype wire

// File: rtl/model_reader.sv
// ============================================================================
// model_reader : streams one stored model's triangles out of the model buffer
//                in index order over valid/ready, then pulses done.
// Optional: define MODEL_READER_ABORT_EN to add an abort input.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module model_reader
  import model_reader_pkg::*;
#(
  parameter int MAX_MODEL_COUNT    = 10,
  parameter int MAX_TRIANGLE_COUNT = 100
) (
  input  logic                                  clk,
  input  logic                                  rst,
`ifdef MODEL_READER_ABORT_EN
  input  logic                                  abort,
`endif
  input  logic                                  start,
  input  logic [$clog2(MAX_MODEL_COUNT)-1:0]    start_model_index,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(MAX_MODEL_COUNT)-1:0]    read_model_index,
  output logic [$clog2(MAX_TRIANGLE_COUNT)-1:0] read_triangle_index,
  input  triangle_t                             read_triangle,
  input  logic                                  read_last_index,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output triangle_t                             out_triangle,
  output logic [$clog2(MAX_TRIANGLE_COUNT)-1:0] out_triangle_index,
  output logic                                  out_last
);

  localparam int c_tri_w = $clog2(MAX_TRIANGLE_COUNT);
  localparam logic [c_tri_w-1:0] c_idx_max = c_tri_w'(MAX_TRIANGLE_COUNT - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_tri_w-1:0] r_idx;
  logic               r_fetched_last;

  logic w_load;
  logic w_last;
  logic w_abort;

`ifdef MODEL_READER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // The index cap terminates empty or unterminated models without wrapping.
  assign w_load = !out_valid || out_ready;
  assign w_last = read_last_index || (r_idx == c_idx_max);

  assign busy                = (r_state == ST_STREAM);
  assign read_triangle_index = r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_idx              <= '0;
      r_fetched_last     <= 1'b0;
      read_model_index   <= '0;
      done               <= 1'b0;
      out_valid          <= 1'b0;
      out_triangle       <= '0;
      out_triangle_index <= '0;
      out_last           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            read_model_index <= start_model_index;
            r_idx            <= '0;
            r_fetched_last   <= 1'b0;
            r_state          <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_load) begin
            if (!r_fetched_last) begin
              out_triangle       <= read_triangle;
              out_triangle_index <= r_idx;
              out_last           <= w_last;
              out_valid          <= 1'b1;
              r_fetched_last     <= w_last;
              if (!w_last) begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_model_reader.sv
// Scoreboard bench for model_reader: directed model streams against a small
// behavioural model buffer; a negedge monitor pops and compares accepted beats.
`default_nettype none

module tb_model_reader;
  import model_reader_pkg::*;

  localparam int MMC = 10;
  localparam int MTC = 4;
  localparam int MW  = $clog2(MMC);
  localparam int TW  = $clog2(MTC);

  // Model lengths in the buffer; 0 means read_last_index is never raised.
  localparam int MODEL_LEN [MMC] = '{2, 1, 3, 2, 4, 0, 3, 1, 2, 0};

  typedef struct packed {
    triangle_t     tri_v;
    logic [TW-1:0] idx;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [MW-1:0]   start_model_index = '0;
  logic            busy;
  logic            done;
  logic [MW-1:0]   read_model_index;
  logic [TW-1:0]   read_triangle_index;
  triangle_t       read_triangle;
  logic            read_last_index;
  logic            out_valid;
  logic            out_ready;
  triangle_t       out_triangle;
  logic [TW-1:0]   out_triangle_index;
  logic            out_last;
`ifdef MODEL_READER_ABORT_EN
  logic            abort = 1'b0;
`endif

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     done_seen = 0;
  int     done_exp = 0;
  beat_t  exp_q[$];

  logic       ready_auto = 1'b1;
  logic       ready_manual = 1'b0;
  logic [7:0] ready_pat = 8'hFF;
  int         ready_len = 1;
  int         ready_base = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign out_ready = ready_auto ? ready_pat[(cyc - ready_base) % ready_len] : ready_manual;

  function automatic triangle_t make_tri(int m, int i);
    triangle_t t;
    t.v0.x = fixed_t'(m * 4096 + i * 16 + 1);
    t.v0.y = fixed_t'(m * 4096 + i * 16 + 2);
    t.v0.z = fixed_t'(m * 4096 + i * 16 + 3);
    t.v1.x = fixed_t'(m * 4096 + i * 16 + 4);
    t.v1.y = fixed_t'(m * 4096 + i * 16 + 5);
    t.v1.z = fixed_t'(m * 4096 + i * 16 + 6);
    t.v2.x = fixed_t'(-(m * 256 + i));
    t.v2.y = fixed_t'(m * 256 + i * 8 + 7);
    t.v2.z = fixed_t'(16'h7000 + m * 16 + i);
    return t;
  endfunction

  // Behavioural model buffer: combinational read of the presented indices.
  always_comb begin
    int len;
    len             = MODEL_LEN[int'(read_model_index)];
    read_triangle   = make_tri(int'(read_model_index), int'(read_triangle_index));
    read_last_index = (len != 0) && (int'(read_triangle_index) == len - 1);
  end

  model_reader #(
    .MAX_MODEL_COUNT   (MMC),
    .MAX_TRIANGLE_COUNT(MTC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
`ifdef MODEL_READER_ABORT_EN
    .abort              (abort),
`endif
    .start              (start),
    .start_model_index  (start_model_index),
    .busy               (busy),
    .done               (done),
    .read_model_index   (read_model_index),
    .read_triangle_index(read_triangle_index),
    .read_triangle      (read_triangle),
    .read_last_index    (read_last_index),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_triangle       (out_triangle),
    .out_triangle_index (out_triangle_index),
    .out_last           (out_last)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beats for a full stream of model m (capped at MTC triangles).
  task automatic push_model(int m);
    int n;
    beat_t b;
    n = (MODEL_LEN[m] == 0 || MODEL_LEN[m] > MTC) ? MTC : MODEL_LEN[m];
    for (int i = 0; i < n; i++) begin
      b.tri_v = make_tri(m, i);
      b.idx   = TW'(i);
      b.last  = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // Called just after a posedge; start is sampled on the following edge (E0).
  task automatic start_model(int m);
    start             = 1'b1;
    start_model_index = MW'(m);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    logic found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(posedge clk);
      #1;
      if (done) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(logic [7:0] pat, int len);
    ready_auto = 1'b1;
    ready_pat  = pat;
    ready_len  = len;
    ready_base = cyc;
  endtask

  // Monitor: scoreboard pops on each accepted beat; also checks hold stability.
  logic          stall_prev = 1'b0;
  logic          rst_prev = 1'b1;
  triangle_t     held_tri;
  logic [TW-1:0] held_idx;
  logic          held_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && stall_prev && !rst_prev) begin
        checks++;
        if (out_triangle !== held_tri || out_triangle_index !== held_idx ||
            out_last !== held_last) begin
          errors++;
          $display("FAIL stall_hold: got idx=%0d last=%0b tri=%h expected idx=%0d last=%0b tri=%h",
                   out_triangle_index, out_last, out_triangle, held_idx, held_last, held_tri);
        end
      end
      if (out_valid && out_ready) begin
        beat_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got idx=%0d tri=%h expected no beat",
                   out_triangle_index, out_triangle);
        end else begin
          e = exp_q.pop_front();
          if (out_triangle !== e.tri_v || out_triangle_index !== e.idx || out_last !== e.last) begin
            errors++;
            $display("FAIL beat: got idx=%0d last=%0b tri=%h expected idx=%0d last=%0b tri=%h",
                     out_triangle_index, out_last, out_triangle, e.idx, e.last, e.tri_v);
          end
        end
      end
      if (done) begin
        done_seen++;
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_valid_low", 32'(out_valid), 32'd0);
      end
    end
    stall_prev = out_valid && !out_ready;
    rst_prev   = rst;
    held_tri   = out_triangle;
    held_idx   = out_triangle_index;
    held_last  = out_last;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_tri", 32'(out_triangle == '0), 32'd1);
    check("rst_out_idx", 32'(out_triangle_index), 32'd0);
    check("rst_rd_model", 32'(read_model_index), 32'd0);
    check("rst_rd_idx", 32'(read_triangle_index), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Model 2 (3 triangles), ready held high: cycle-exact timing.
    set_ready(8'hFF, 1);
    push_model(2);
    start_model(2);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_valid_e0", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_idx", 32'(out_triangle_index), 32'(k - 1));
      check("t1_last", 32'(out_last), 32'(k == 3));
      check("t1_done_low", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    done_exp++;
    check("t1_done_e4", 32'(done), 32'd1);
    check("t1_busy_e4", 32'(busy), 32'd0);
    check("t1_valid_e4", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_1cyc", 32'(done), 32'd0);

    // Same model with ready toggling 1,0,0,1,1.
    set_ready(8'b0001_1001, 5);
    push_model(2);
    start_model(2);
    done_exp++;
    wait_done("t2_done", 40);

    // Unterminated model: capped at MTC triangles.
    set_ready(8'hFF, 1);
    push_model(5);
    start_model(5);
    done_exp++;
    wait_done("t3_done", 20);

    // Single-triangle model with slow downstream.
    set_ready(8'b0000_0100, 3);
    push_model(7);
    start_model(7);
    done_exp++;
    wait_done("t3b_done", 20);

    // Start during STREAM with another model is ignored.
    set_ready(8'hFF, 1);
    push_model(2);
    start_model(2);
    @(posedge clk);
    #1;
    start             = 1'b1;
    start_model_index = MW'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_rd_model", 32'(read_model_index), 32'd2);
    done_exp++;
    wait_done("t4_done", 20);
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_restart", 32'(busy), 32'd0);

    // rst while index 1 is presented but not accepted.
    ready_auto   = 1'b0;
    ready_manual = 1'b0;
    push_model(2);
    start_model(2);
    @(posedge clk);
    #1;
    check("t5_idx0", 32'(out_triangle_index), 32'd0);
    ready_manual = 1'b1;
    @(posedge clk);
    #1;
    check("t5_idx1_valid", 32'(out_valid), 32'd1);
    check("t5_idx1", 32'(out_triangle_index), 32'd1);
    ready_manual = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    set_ready(8'hFF, 1);
    push_model(0);
    start_model(0);
    done_exp++;
    wait_done("t5_restart_done", 20);

`ifdef MODEL_READER_ABORT_EN
    ready_auto   = 1'b0;
    ready_manual = 1'b0;
    push_model(2);
    start_model(2);
    @(posedge clk);
    #1;
    ready_manual = 1'b1;
    @(posedge clk);
    #1;
    check("t6_idx1", 32'(out_triangle_index), 32'd1);
    ready_manual = 1'b0;
    abort        = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_still_idle", 32'(busy), 32'd0);
    set_ready(8'hFF, 1);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_seen), 32'(done_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
